axi_lite_master: RTL and testbench

AXI4-Lite initiator that turns single-word requests from a simple valid/ready command port into AXI4-Lite read or write transactions on the `cbus_*` control bus, and returns the response on a valid/ready response port. It sits between a local sequencer or host bridge and the register slaves hanging off `cbus`. Only one transaction is outstanding at a time; there is no reordering or pipelining.

---
 rtl/axi_lite_master.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// axi_lite_master
// ---------------------------------------------------------------------------
// AXI4-Lite initiator. Accepts one single-word read or write command at a time
// on a valid/ready request port, performs the corresponding AXI4-Lite
// transaction on the cbus_* control bus, and returns the result on a
// valid/ready response port. There is exactly one transaction outstanding at a
// time, with no pipelining or reordering.
//
// Handshake rule (every valid/ready pair in this block): a transfer happens on
// a rising clk edge where both valid and ready are sampled high. Once a valid
// is raised, it and its payload stay stable until that edge.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         command handshake (req_ready is high in IDLE)
//   req_write                   1 = write, 0 = read
//   req_addr/req_wdata/req_wstrb command payload, latched on acceptance
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata                   read data (0 for writes and timeouts)
//   rsp_resp                    BRESP/RRESP (2'b10 on timeout)
//   rsp_timeout                 transaction aborted by the watchdog
//   cbus_aw*/w*/b*/ar*/r*       AXI4-Lite master port set
//
// Optional feature
//   AXI_LITE_MASTER_TIMEOUT_EN  when defined, a watchdog aborts any transaction
//                               that spends TIMEOUT cycles on the bus and
//                               reports SLVERR with rsp_timeout=1. When not
//                               defined there is no counter, rsp_timeout is 0
//                               and the master waits indefinitely.
// ---------------------------------------------------------------------------
module axi_lite_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,

    output logic [ADDR_WIDTH-1:0]   cbus_awaddr,
    output logic [2:0]              cbus_awprot,
    output logic                    cbus_awvalid,
    input  logic                    cbus_awready,

    output logic [DATA_WIDTH-1:0]   cbus_wdata,
    output logic [DATA_WIDTH/8-1:0] cbus_wstrb,
    output logic                    cbus_wvalid,
    input  logic                    cbus_wready,

    input  logic [1:0]              cbus_bresp,
    input  logic                    cbus_bvalid,
    output logic                    cbus_bready,

    output logic [ADDR_WIDTH-1:0]   cbus_araddr,
    output logic [2:0]              cbus_arprot,
    output logic                    cbus_arvalid,
    input  logic                    cbus_arready,

    input  logic [DATA_WIDTH-1:0]   cbus_rdata,
    input  logic [1:0]              cbus_rresp,
    input  logic                    cbus_rvalid,
    output logic                    cbus_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } state_t;

    state_t                  state;

    // Latched request payload, held for the whole transaction.
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;

    // AW and W complete independently; these remember which one is done.
    logic                    aw_done;
    logic                    w_done;
    logic                    aw_done_next;
    logic                    w_done_next;

    logic                    busy;       // a bus transaction is in flight
    logic                    finishing;  // the current bus phase completes this cycle
    logic                    tmo_hit;    // watchdog expires at the coming edge

    assign aw_done_next = aw_done | (cbus_awvalid & cbus_awready);
    assign w_done_next  = w_done  | (cbus_wvalid  & cbus_wready);

    assign busy = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                  (state == RD_ADDR)      || (state == RD_DATA);

    // A phase that completes in the same cycle the watchdog expires is
    // allowed to finish normally.
    always_comb begin
        finishing = 1'b0;
        case (state)
            WR_ADDR_DATA: finishing = aw_done_next && w_done_next;
            WR_RESP:      finishing = cbus_bvalid;
            RD_ADDR:      finishing = cbus_arvalid && cbus_arready;
            RD_DATA:      finishing = cbus_rvalid;
            default:      finishing = 1'b0;
        endcase
    end

    // Payload outputs simply mirror the latched request.
    assign cbus_awaddr = addr_q;
    assign cbus_araddr = addr_q;
    assign cbus_wdata  = wdata_q;
    assign cbus_wstrb  = wstrb_q;

    // Unprivileged, secure, data access.
    assign cbus_awprot = 3'b000;
    assign cbus_arprot = 3'b000;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_q;

    // tmo_cnt counts completed busy cycles; when it equals TIMEOUT-1 the
    // current cycle is the TIMEOUT-th one on the bus.
    assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign rsp_timeout = tmo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE && req_valid) begin
            tmo_cnt <= '0;
        end else if (busy) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
    assign rsp_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            cbus_awvalid <= 1'b0;
            cbus_wvalid  <= 1'b0;
            cbus_bready  <= 1'b0;
            cbus_arvalid <= 1'b0;
            cbus_rready  <= 1'b0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            tmo_q        <= 1'b0;
`endif
        end else if (busy && tmo_hit && !finishing) begin
            // Watchdog abort: withdraw everything from the bus and report SLVERR.
            cbus_awvalid <= 1'b0;
            cbus_wvalid  <= 1'b0;
            cbus_bready  <= 1'b0;
            cbus_arvalid <= 1'b0;
            cbus_rready  <= 1'b0;
            rsp_rdata    <= '0;
            rsp_resp     <= 2'b10;
            rsp_valid    <= 1'b1;
            state        <= RESP;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
            tmo_q        <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        req_ready <= 1'b0;
                        if (req_write) begin
                            // AW and W are offered together; W never waits for AW.
                            cbus_awvalid <= 1'b1;
                            cbus_wvalid  <= 1'b1;
                            state        <= WR_ADDR_DATA;
                        end else begin
                            cbus_arvalid <= 1'b1;
                            state        <= RD_ADDR;
                        end
                    end
                end

                WR_ADDR_DATA: begin
                    if (cbus_awvalid && cbus_awready) begin
                        cbus_awvalid <= 1'b0;
                    end
                    if (cbus_wvalid && cbus_wready) begin
                        cbus_wvalid <= 1'b0;
                    end
                    aw_done <= aw_done_next;
                    w_done  <= w_done_next;
                    if (aw_done_next && w_done_next) begin
                        cbus_bready <= 1'b1;
                        state       <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (cbus_bvalid) begin
                        cbus_bready <= 1'b0;
                        rsp_resp    <= cbus_bresp;
                        rsp_rdata   <= '0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end

                RD_ADDR: begin
                    if (cbus_arready) begin
                        cbus_arvalid <= 1'b0;
                        cbus_rready  <= 1'b1;
                        state        <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (cbus_rvalid) begin
                        cbus_rready <= 1'b0;
                        rsp_rdata   <= cbus_rdata;
                        rsp_resp    <= cbus_rresp;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    // Response outputs stay frozen until the consumer takes them.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
                        tmo_q     <= 1'b0;
`endif
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master
// ---------------------------------------------------------------------------
// Bench for axi_lite_master. A behavioural AXI4-Lite slave with per-channel
// ready delays and a small word memory sits on cbus. Directed requests push
// their hand-computed response into exp_q; a monitor pops and compares on
// every response handshake. Timeout vectors run only when
// AXI_LITE_MASTER_TIMEOUT_EN is defined (TIMEOUT is set to 16 here).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_lite_master;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;
    localparam int EW  = DW + 3;   // {timeout, resp[1:0], rdata}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;

    logic [AW-1:0] cbus_awaddr;
    logic [2:0]    cbus_awprot;
    logic          cbus_awvalid;
    logic          cbus_awready;
    logic [DW-1:0] cbus_wdata;
    logic [SW-1:0] cbus_wstrb;
    logic          cbus_wvalid;
    logic          cbus_wready;
    logic [1:0]    cbus_bresp  = 2'b00;
    logic          cbus_bvalid = 1'b0;
    logic          cbus_bready;
    logic [AW-1:0] cbus_araddr;
    logic [2:0]    cbus_arprot;
    logic          cbus_arvalid;
    logic          cbus_arready;
    logic [DW-1:0] cbus_rdata  = '0;
    logic [1:0]    cbus_rresp  = 2'b00;
    logic          cbus_rvalid = 1'b0;
    logic          cbus_rready;

    axi_lite_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .cbus_awaddr  (cbus_awaddr),
        .cbus_awprot  (cbus_awprot),
        .cbus_awvalid (cbus_awvalid),
        .cbus_awready (cbus_awready),
        .cbus_wdata   (cbus_wdata),
        .cbus_wstrb   (cbus_wstrb),
        .cbus_wvalid  (cbus_wvalid),
        .cbus_wready  (cbus_wready),
        .cbus_bresp   (cbus_bresp),
        .cbus_bvalid  (cbus_bvalid),
        .cbus_bready  (cbus_bready),
        .cbus_araddr  (cbus_araddr),
        .cbus_arprot  (cbus_arprot),
        .cbus_arvalid (cbus_arvalid),
        .cbus_arready (cbus_arready),
        .cbus_rdata   (cbus_rdata),
        .cbus_rresp   (cbus_rresp),
        .cbus_rvalid  (cbus_rvalid),
        .cbus_rready  (cbus_rready)
    );

    // ---------------- slave model ----------------
    int            aw_delay   = 1;
    int            w_delay    = 1;
    int            ar_delay   = 1;
    logic [1:0]    bresp_cfg  = 2'b00;
    logic [1:0]    rresp_cfg  = 2'b00;
    logic          b_block    = 1'b0;
    logic          b_flush    = 1'b0;

    int            aw_wait    = 0;
    int            w_wait     = 0;
    int            ar_wait    = 0;
    logic          aw_got     = 1'b0;
    logic          w_got      = 1'b0;
    logic [AW-1:0] aw_addr_s  = '0;
    logic [DW-1:0] w_data_s   = '0;
    logic [SW-1:0] w_strb_s   = '0;
    logic [DW-1:0] mem [0:255];

    logic          aw_hs;
    logic          w_hs;
    logic          aw_have;
    logic          w_have;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic [SW-1:0] b_strb;
    logic [DW-1:0] b_mask;

    assign cbus_awready = cbus_awvalid && !aw_got && (aw_wait >= aw_delay);
    assign cbus_wready  = cbus_wvalid  && !w_got  && (w_wait  >= w_delay);
    assign cbus_arready = cbus_arvalid && (ar_wait >= ar_delay);

    assign aw_hs   = cbus_awvalid && cbus_awready;
    assign w_hs    = cbus_wvalid && cbus_wready;
    assign aw_have = aw_got || aw_hs;
    assign w_have  = w_got || w_hs;
    assign b_addr  = aw_got ? aw_addr_s : cbus_awaddr;
    assign b_data  = w_got ? w_data_s : cbus_wdata;
    assign b_strb  = w_got ? w_strb_s : cbus_wstrb;
    assign b_mask  = {{8{b_strb[3]}}, {8{b_strb[2]}}, {8{b_strb[1]}}, {8{b_strb[0]}}};

    always @(posedge clk) begin
        if (b_flush) begin
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            cbus_bvalid <= 1'b0;
            aw_wait     <= 0;
            w_wait      <= 0;
        end else begin
            aw_wait <= (cbus_awvalid && !cbus_awready) ? aw_wait + 1 : 0;
            w_wait  <= (cbus_wvalid && !cbus_wready) ? w_wait + 1 : 0;
            if (cbus_bvalid && cbus_bready) begin
                cbus_bvalid <= 1'b0;
            end
            // B goes out in the cycle right after the last of AW/W completes.
            if (!cbus_bvalid && aw_have && w_have && !b_block) begin
                cbus_bvalid  <= 1'b1;
                cbus_bresp   <= bresp_cfg;
                mem[b_addr]  <= (mem[b_addr] & ~b_mask) | (b_data & b_mask);
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_got    <= 1'b1;
                    aw_addr_s <= cbus_awaddr;
                end
                if (w_hs) begin
                    w_got    <= 1'b1;
                    w_data_s <= cbus_wdata;
                    w_strb_s <= cbus_wstrb;
                end
            end
        end
        ar_wait <= (cbus_arvalid && !cbus_arready) ? ar_wait + 1 : 0;
        if (cbus_rvalid && cbus_rready) begin
            cbus_rvalid <= 1'b0;
        end
        if (cbus_arvalid && cbus_arready) begin
            cbus_rvalid <= 1'b1;
            cbus_rdata  <= mem[cbus_araddr];
            cbus_rresp  <= rresp_cfg;
        end
    end

    // Bus activity counters, sampled mid-cycle.
    int aw_hi = 0;
    int w_hi  = 0;
    int ar_hi = 0;
    int b_hs  = 0;
    always @(negedge clk) begin
        if (cbus_awvalid) aw_hi <= aw_hi + 1;
        if (cbus_wvalid)  w_hi  <= w_hi + 1;
        if (cbus_arvalid) ar_hi <= ar_hi + 1;
        if (cbus_bvalid && cbus_bready) b_hs <= b_hs + 1;
    end

    // ---------------- scoreboard ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [EW-1:0] exp_q[$];

    function automatic logic [EW-1:0] mk(input logic t, input logic [1:0] r, input logic [DW-1:0] d);
        return {t, r, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rdata=0x%0h resp=%0d, expected no response (t=%0t)",
                             rsp_rdata, rsp_resp, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata",   64'(rsp_rdata),   64'(e[DW-1:0]));
                    check("rsp_resp",    64'(rsp_resp),    64'(e[DW+1:DW]));
                    check("rsp_timeout", 64'(rsp_timeout), 64'(e[DW+2]));
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Returns at #1 after the accepting edge, i.e. in the first bus cycle.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [EW-1:0] e, input bit push);
        int cyc = 0;
        if (push) exp_q.push_back(e);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        while (!req_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_accept: got req_ready=0 for 100 cycles, expected acceptance");
            req_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d responses outstanding after 200 cycles, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        int w0;
        int b0;
        int cyc;

        fork
            monitor();
        join_none

        // Reset values, checked while reset is held.
        cycles(3);
        check("rst_req_ready",   64'(req_ready),    64'd1);
        check("rst_awvalid",     64'(cbus_awvalid), 64'd0);
        check("rst_wvalid",      64'(cbus_wvalid),  64'd0);
        check("rst_arvalid",     64'(cbus_arvalid), 64'd0);
        check("rst_bready",      64'(cbus_bready),  64'd0);
        check("rst_rready",      64'(cbus_rready),  64'd0);
        check("rst_rsp_valid",   64'(rsp_valid),    64'd0);
        check("rst_rsp_rdata",   64'(rsp_rdata),    64'd0);
        check("rst_rsp_resp",    64'(rsp_resp),     64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout),  64'd0);
        check("rst_awaddr",      64'(cbus_awaddr),  64'd0);
        check("rst_wdata",       64'(cbus_wdata),   64'd0);
        check("rst_prot",        64'({cbus_awprot, cbus_arprot}), 64'd0);
        rst = 1'b0;
        cycles(1);

        // Registered-ready slave: write then read back.
        aw_delay = 1; w_delay = 1; ar_delay = 1;
        send(1'b1, 8'd1, 32'hDEADBEEF, 4'hF, mk(1'b0, 2'b00, 32'h0), 1'b1);
        check("wr_awvalid_n1", 64'(cbus_awvalid), 64'd1);
        check("wr_wvalid_n1",  64'(cbus_wvalid),  64'd1);
        check("wr_awaddr",     64'(cbus_awaddr),  64'd1);
        check("wr_wdata",      64'(cbus_wdata),   64'hDEADBEEF);
        wait_drain();
        send(1'b0, 8'd1, 32'h0, 4'h0, mk(1'b0, 2'b00, 32'hDEADBEEF), 1'b1);
        check("rd_arvalid_n1", 64'(cbus_arvalid), 64'd1);
        wait_drain();

        // Same-cycle-ready slave: rsp_valid rises 3 cycles after acceptance.
        aw_delay = 0; w_delay = 0; ar_delay = 0;
        send(1'b1, 8'd3, 32'h12345678, 4'hF, mk(1'b0, 2'b00, 32'h0), 1'b1);
        check("wr_lat_n1", 64'(rsp_valid), 64'd0);
        cycles(1);
        check("wr_lat_n2", 64'(rsp_valid), 64'd0);
        cycles(1);
        check("wr_lat_n3", 64'(rsp_valid), 64'd1);
        wait_drain();
        send(1'b0, 8'd3, 32'h0, 4'h0, mk(1'b0, 2'b00, 32'h12345678), 1'b1);
        cycles(1);
        check("rd_lat_n2", 64'(rsp_valid), 64'd0);
        cycles(1);
        check("rd_lat_n3", 64'(rsp_valid), 64'd1);
        wait_drain();

        // AW delayed 3 cycles, W immediate.
        aw_delay = 3; w_delay = 0;
        a0 = aw_hi; w0 = w_hi; b0 = b_hs;
        send(1'b1, 8'd4, 32'hCAFEF00D, 4'hF, mk(1'b0, 2'b00, 32'h0), 1'b1);
        wait_drain();
        cycles(2);
        check("aw_late_awvalid_cycles", 64'(aw_hi - a0), 64'd4);
        check("aw_late_wvalid_cycles",  64'(w_hi - w0),  64'd1);
        check("aw_late_b_handshakes",   64'(b_hs - b0),  64'd1);

        // Error BRESP passes through.
        aw_delay = 1; w_delay = 1;
        bresp_cfg = 2'b11;
        send(1'b1, 8'd5, 32'h0BADF00D, 4'hF, mk(1'b0, 2'b11, 32'h0), 1'b1);
        wait_drain();
        bresp_cfg = 2'b00;

        // Read of 0xA5 with arready delayed; arvalid held until arready.
        send(1'b1, 8'd2, 32'h000000A5, 4'hF, mk(1'b0, 2'b00, 32'h0), 1'b1);
        wait_drain();
        ar_delay = 2;
        a0 = ar_hi;
        send(1'b0, 8'd2, 32'h0, 4'h0, mk(1'b0, 2'b00, 32'h000000A5), 1'b1);
        wait_drain();
        check("ar_held_cycles", 64'(ar_hi - a0), 64'd3);

        // Partial strobe: bytes 0 and 2 written -> 0x00220044; RRESP=1 passes through.
        ar_delay = 1;
        send(1'b1, 8'd2, 32'h11223344, 4'b0101, mk(1'b0, 2'b00, 32'h0), 1'b1);
        wait_drain();
        rresp_cfg = 2'b01;
        send(1'b0, 8'd2, 32'h0, 4'h0, mk(1'b0, 2'b01, 32'h00220044), 1'b1);
        wait_drain();
        rresp_cfg = 2'b00;

        // Back-pressure on the response port.
        rsp_ready = 1'b0;
        send(1'b0, 8'd2, 32'h0, 4'h0, mk(1'b0, 2'b00, 32'h00220044), 1'b1);
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            cycles(1);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_rdata", 64'(rsp_rdata), 64'h00220044);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            cycles(1);
        end
        rsp_ready = 1'b1;
        cycles(1);
        check("release_req_ready", 64'(req_ready), 64'd1);
        check("release_rsp_valid", 64'(rsp_valid), 64'd0);

        // Reset while waiting for B; the late B must be ignored.
        b_block = 1'b1;
        send(1'b1, 8'd6, 32'h55AA55AA, 4'hF, mk(1'b0, 2'b00, 32'h0), 1'b0);
        cyc = 0;
        while (!cbus_bready && cyc < 50) begin
            cycles(1);
            cyc++;
        end
        check("wr_resp_bready", 64'(cbus_bready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_bready",    64'(cbus_bready),  64'd0);
        check("midrst_awvalid",   64'(cbus_awvalid), 64'd0);
        check("midrst_wvalid",    64'(cbus_wvalid),  64'd0);
        check("midrst_arvalid",   64'(cbus_arvalid), 64'd0);
        check("midrst_rready",    64'(cbus_rready),  64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid),    64'd0);
        @(negedge clk);
        rst = 1'b0;
        b_block = 1'b0;
        b0 = b_hs;
        cycles(5);
        check("late_b_bvalid",     64'(cbus_bvalid), 64'd1);
        check("late_b_bready",     64'(cbus_bready), 64'd0);
        check("late_b_handshakes", 64'(b_hs - b0),   64'd0);
        check("late_b_req_ready",  64'(req_ready),   64'd1);
        b_flush = 1'b1;
        cycles(1);
        b_flush = 1'b0;
        send(1'b0, 8'd1, 32'h0, 4'h0, mk(1'b0, 2'b00, 32'hDEADBEEF), 1'b1);
        wait_drain();

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        // Slave never asserts arready: abort after TIMEOUT cycles with SLVERR.
        ar_delay = 1000;
        a0 = ar_hi;
        send(1'b0, 8'd7, 32'h0, 4'h0, mk(1'b1, 2'b10, 32'h0), 1'b1);
        wait_drain();
        check("tmo_arvalid_cycles", 64'(ar_hi - a0),   64'd16);
        check("tmo_arvalid_after",  64'(cbus_arvalid), 64'd0);
        ar_delay = 1;
        send(1'b0, 8'd1, 32'h0, 4'h0, mk(1'b0, 2'b00, 32'hDEADBEEF), 1'b1);
        wait_drain();
`endif

        cycles(3);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
